// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq - multi-cycle calculator ALU
//
// Takes one operation per start/ready handshake and returns a registered
// result with a one-cycle valid_o pulse.
//   add, sub, eq, lt, reserved and divide-by-zero : one cycle
//   mul (shift-add) and div (restoring)           : WIDTH iteration cycles
//
// Handshake: an operation is accepted on a rising edge where
// start_i && ready_o. ready_o is high only while idle. start_i while busy is
// dropped, not queued. valid_o pulses for exactly one cycle when
// s_o/signal_o/err_o are rewritten; the outputs hold between pulses.
//
// Configuration macro: ALU_DIV_EN
//   defined   : opcode 100 runs the restoring divider
//   undefined : divider not built, opcode 100 behaves as a reserved opcode
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous reset, active-high
//   start_i  in   operation request
//   a_i      in   operand A (unsigned), sampled on accept
//   b_i      in   operand B (unsigned), sampled on accept
//   fct_i    in   opcode, sampled on accept
//   ready_o  out  idle and able to accept
//   s_o      out  2*WIDTH-bit result
//   signal_o out  compare / borrow flag
//   err_o    out  divide-by-zero or reserved opcode
//   valid_o  out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2:0]           fct_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   s_o,
    output logic                 signal_o,
    output logic                 err_o,
    output logic                 valid_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W = '0;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1} state_t;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    s_q, s_d;
    logic                  signal_q, signal_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;

    // Multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier.
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [2*WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [2*WIDTH-1:0]    acc_sum;

    logic [2*WIDTH-1:0]    a_ext, b_ext;

    assign a_ext   = {ZERO_W, a_i};
    assign b_ext   = {ZERO_W, b_i};
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef ALU_DIV_EN
    // Divider: remainder, dividend register that fills with quotient bits
    // from the right, and the divisor. rem_shift carries the guard bit.
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]      dq_q, dq_d;
    logic [WIDTH-1:0]      dvs_q, dvs_d;
    logic [WIDTH:0]        rem_shift;
    logic                  q_bit;
    logic [WIDTH-1:0]      rem_next;

    assign rem_shift = {rem_q, dq_q[WIDTH-1]};
    assign q_bit     = (rem_shift >= {1'b0, dvs_q});
    // When q_bit is set the true difference is below the divisor, so the
    // low WIDTH bits of the modular subtraction are exact.
    assign rem_next  = q_bit ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        signal_d = signal_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`ifdef ALU_DIV_EN
        rem_d    = rem_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // Single-cycle results default to a completion with
                    // err_o clear; multi-cycle opcodes cancel the pulse below.
                    valid_d  = 1'b1;
                    s_d      = '0;
                    signal_d = 1'b0;
                    err_d    = 1'b0;
                    case (fct_i)
                        3'b000: s_d = a_ext + b_ext;
                        3'b001: begin
                            s_d      = a_ext - b_ext;
                            signal_d = (a_i < b_i);
                        end
                        3'b010: begin
                            valid_d  = 1'b0;
                            s_d      = s_q;
                            signal_d = signal_q;
                            err_d    = err_q;
                            state_d  = ST_MUL;
                            cnt_d    = '0;
                            acc_d    = '0;
                            mcand_d  = a_ext;
                            mplier_d = b_i;
                        end
                        3'b011: signal_d = (a_i == b_i);
`ifdef ALU_DIV_EN
                        3'b100: begin
                            if (b_i == ZERO_W) begin
                                s_d   = {a_i, {WIDTH{1'b1}}};
                                err_d = 1'b1;
                            end else begin
                                valid_d  = 1'b0;
                                s_d      = s_q;
                                signal_d = signal_q;
                                err_d    = err_q;
                                state_d  = ST_DIV;
                                cnt_d    = '0;
                                rem_d    = '0;
                                dq_d     = a_i;
                                dvs_d    = b_i;
                            end
                        end
`endif
                        3'b101: signal_d = (a_i < b_i);
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    s_d      = acc_sum;
                    signal_d = 1'b0;
                    err_d    = 1'b0;
                    valid_d  = 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                rem_d = rem_next;
                dq_d  = {dq_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    s_d      = {rem_next, dq_q[WIDTH-2:0], q_bit};
                    signal_d = 1'b0;
                    err_d    = 1'b0;
                    valid_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            s_q      <= '0;
            signal_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef ALU_DIV_EN
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            signal_q <= signal_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`ifdef ALU_DIV_EN
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
`endif
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign s_o      = s_q;
    assign signal_o = signal_q;
    assign err_o    = err_q;
    assign valid_o  = valid_q;

endmodule
